// File: rtl/disp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | disp_pkg: shared constants, FSM encoding and types for the scan   |
// | controller.                                 Revision: 1.0         |
// +------------------------------------------------------------------+
package disp_pkg;

   localparam int         NUM_DIGITS = 4;
   localparam logic [3:0] ANODE_OFF  = 4'b1111;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;

   localparam logic [1:0] ST_GUARD = 2'd0;
   localparam logic [1:0] ST_ON    = 2'd1;
   localparam logic [1:0] ST_OFF   = 2'd2;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  dp;
      logic        lz_en;
   } disp_word_t;

   // Bit k set means digit k is suppressed as a leading zero; digit 0 never is.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(input disp_word_t w);
      logic [NUM_DIGITS-1:0] m;
      logic                  zero_above;
      m          = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above & (w.data[4*k +: 4] == 4'h0);
         m[k]       = w.lz_en & zero_above;
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg_encoder: hex nibble to active-low gfedcba glyph (0-F).        |
// |                                             Revision: 1.0         |
// +------------------------------------------------------------------+
module seg_encoder (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seven_seg_scan_ctrl: 4-digit multiplexed 7-seg driver with guard  |
// | blanking, PWM brightness and a double-buffered load port.         |
// |                                             Revision: 1.0         |
// +------------------------------------------------------------------+
module seven_seg_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned GUARD    = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_data,
   input  logic [3:0]  load_dp,
   input  logic        lz_en,
   input  logic [2:0]  bright,
   output logic [3:0]  A_LED,
   output logic [6:0]  C_LED,
   output logic        DP_LED,
   output logic        frame_start
);

   localparam int unsigned      CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [31:0]      SPAN     = 32'(TICK_DIV - GUARD);

   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_next;
   logic [31:0]           cnt_next_ext;
   logic [1:0]            digit;
   logic [1:0]            state;
   logic [1:0]            state_next;
   logic [2:0]            bright_q;
   logic [2:0]            bright_slot;
   logic [31:0]           on_len;
   logic                  slot_end;
   logic                  frame_end;
   logic                  accept;
   logic                  shadow_full;
   disp_word_t            active;
   disp_word_t            shadow;
   logic [NUM_DIGITS-1:0] blank_mask;
   logic [3:0]            nibble;
   logic [6:0]            glyph;
   logic                  lit;

   assign slot_end     = (cnt == CNT_LAST);
   assign frame_end    = slot_end && (digit == 2'(NUM_DIGITS - 1));
   assign cnt_next     = slot_end ? '0 : cnt + CNT_W'(1);
   assign cnt_next_ext = 32'(cnt_next);
   assign accept       = load_valid && load_ready;

   // Brightness is live only at cnt==0; afterwards the latched copy holds the slot steady.
   assign bright_slot = (cnt == '0) ? bright : bright_q;
   assign on_len      = 32'(GUARD) + (((32'(bright_slot) + 32'd1) * SPAN) >> 3);

   // State tracks the cnt value it is registered with; the ON window always
   // spans at least one cycle, so GUARD can hand straight over to ON.
   always_comb begin
      state_next = state;
      if (slot_end) begin
         state_next = (GUARD > 0) ? ST_GUARD : ST_ON;
      end else begin
         case (state)
            ST_GUARD: if (cnt_next_ext >= 32'(GUARD)) state_next = ST_ON;
            ST_ON:    if (cnt_next_ext >= on_len)     state_next = ST_OFF;
            ST_OFF:   state_next = ST_OFF;
            default:  state_next = ST_GUARD;
         endcase
      end
   end

   assign nibble     = active.data[4*digit +: 4];
   assign blank_mask = lz_mask(active);
   assign lit        = (state == ST_ON) && !blank_mask[digit];

   seg_encoder u_seg_encoder (
      .hex (nibble),
      .seg (glyph)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt         <= '0;
         digit       <= '0;
         state       <= ST_GUARD;
         bright_q    <= '0;
         active      <= '0;
         shadow      <= '0;
         shadow_full <= 1'b0;
         load_ready  <= 1'b0;
         frame_start <= 1'b0;
         A_LED       <= ANODE_OFF;
         C_LED       <= SEG_BLANK;
         DP_LED      <= 1'b1;
      end else begin
         cnt         <= cnt_next;
         state       <= state_next;
         frame_start <= 1'b0;
         if (cnt == '0) bright_q <= bright;
         if (slot_end)  digit    <= digit + 2'd1;

         // Ready is low while the shadow is full, so a boundary swap and a new accept never collide.
         if (frame_end && shadow_full) begin
            active      <= shadow;
            shadow_full <= 1'b0;
            frame_start <= 1'b1;
            load_ready  <= 1'b1;
         end else if (accept) begin
            shadow      <= '{data: load_data, dp: load_dp, lz_en: lz_en};
            shadow_full <= 1'b1;
            load_ready  <= 1'b0;
         end else begin
            load_ready  <= !shadow_full;
         end

         A_LED  <= lit ? ~(4'b0001 << digit) : ANODE_OFF;
         C_LED  <= lit ? glyph : SEG_BLANK;
         DP_LED <= lit ? ~active.dp[digit] : 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, clock cycles per digit slot; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter GUARD, default 4, anti-ghost blank cycles at the start of each slot; SHALL satisfy GUARD < TICK_DIV/2.
REQ-003 clock  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 load_valid  in  1  producer offers a new display word.
REQ-006 load_ready  out  1  shadow buffer empty; a word is accepted when valid and ready are both high.
REQ-007 load_data  in  16  four hex nibbles; digit k uses bits [4k+3:4k].
REQ-008 load_dp  in  4  decimal point per digit, 1 = lit.
REQ-009 lz_en  in  1  leading-zero blanking enable.
REQ-010 bright  in  3  brightness level, 0 = dimmest, 7 = full.
REQ-011 A_LED  out  4  active-low digit anodes; bit k selects digit k.
REQ-012 C_LED  out  7  active-low segments gfedcba.
REQ-013 DP_LED  out  1  active-low decimal point.
REQ-014 frame_start  out  1  one-cycle pulse when the active buffer is updated.

Function
REQ-015 Slot counter cnt SHALL run 0..TICK_DIV-1 and wrap; digit index SHALL advance 0->1->2->3->0 on each wrap.
REQ-016 Per-slot FSM, states GUARD, ON and OFF:
- GUARD while cnt < GUARD.
- ON while GUARD <= cnt < on_len.
- OFF until the slot ends.
REQ-017 on_len SHALL equal GUARD + (((bright+1)*(TICK_DIV-GUARD)) >> 3); bright SHALL be sampled only at cnt==0 and held for the slot.
REQ-018 In GUARD and OFF, A_LED SHALL be 4'b1111, C_LED 7'h7F and DP_LED 1.
REQ-019 In ON, exactly one A_LED bit (the current digit) SHALL be 0, C_LED SHALL show the hex glyph of that digit's nibble from the active buffer, and DP_LED SHALL equal ~dp[digit].
REQ-020 Outputs SHALL be registered; output latency from the cnt/state change is 1 cycle.
REQ-021 A word accepted via load_valid&&load_ready SHALL be written to the shadow buffer (data, dp and lz_en); load_ready SHALL deassert in the following cycle.
REQ-022 Frame boundary is the wrap of digit 3 to digit 0. At the boundary, a full shadow buffer SHALL move to the active buffer, frame_start SHALL pulse, and load_ready SHALL reassert in the next cycle.
REQ-023 If the shadow buffer is empty at the boundary, the active buffer SHALL be unchanged and frame_start SHALL stay 0.
REQ-024 load_valid arriving in the boundary cycle while the shadow buffer is full SHALL not be accepted; the producer holds it.
REQ-025 With lz_en=1 in the active buffer:
- Digit k (k = 3..1) SHALL be blanked when its nibble and all higher nibbles are 0.
- Digit 0 SHALL never be blanked.
- A blanked digit keeps A_LED at 1111 for the whole slot; its DP is also suppressed.
REQ-026 load_data SHALL be ignored while load_ready=0; the producer SHALL hold load_data stable while load_valid=1.

Reset
REQ-027 While reset=1: cnt=0, digit=0, FSM=GUARD, active buffer all zeros with dp=0 and lz_en=0, shadow buffer empty.
REQ-028 Outputs while reset=1: A_LED=4'b1111, C_LED=7'h7F, DP_LED=1, load_ready=0, frame_start=0.
REQ-029 load_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 A reset asserted mid-slot or mid-handshake SHALL discard the shadow buffer and blank all outputs in the next cycle.

Structure
REQ-031 Shared package disp_pkg SHALL hold:
- NUM_DIGITS=4
- ANODE_OFF=4'b1111
- SEG_BLANK=7'h7F
- the FSM state encoding
REQ-032 Hex-to-segment decode SHALL be the combinational sub-module seg_encoder (4-bit in, 7-bit active-low out, glyphs 0-F).

Verification (TICK_DIV=16, GUARD=2)
REQ-033 Reset test: assert reset mid-ON -> next cycle A_LED=1111, C_LED=7F; load_ready=1 on the first cycle after release.
REQ-034 Scan test: load 0x1234, dp=0000, bright=7, lz_en=0.
- After frame_start, A_LED cycles 1110/1101/1011/0111.
- Each anode is low for cycles 2..15 of its slot.
- C_LED shows 4,3,2,1.
REQ-035 Brightness test: bright=0 -> on_len=3, each anode low exactly 1 cycle per slot; bright=3 -> low 7 cycles per slot.
REQ-036 Leading-zero test: 0x0050 with lz_en=1 -> digits 3 and 2 stay dark, digit 1 shows 5, digit 0 shows 0; 0x0000 -> only digit 0 lit, showing 0.
REQ-037 Backpressure test: back-to-back valid with 0x1111 then 0x2222.
- 0x1111 is accepted and load_ready drops.
- 0x2222 is held until the boundary and accepted afterwards.
- The display shows 1111 for one frame, then 2222.
REQ-038 Decimal-point test: dp=0101 -> DP_LED=0 only during ON of digits 0 and 2.
